// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with load, wrap/saturate, compare match,
// sticky overflow and a combinational cascade carry.
module mod_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LDATA,
  input  logic             SAT,
  input  logic [WIDTH-1:0] CMP,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] QOUT,
  output logic             TC,
  output logic             MATCH,
  output logic             OVF
);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end

  // One extra bit so MODULUS = 2^WIDTH needs no special casing.
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   step_ext;
  logic             at_top, at_zero, boundary;
  logic [WIDTH-1:0] eq_bits;

  assign q_ext    = {1'b0, q_reg};
  assign at_top   = (q_ext == TOP);
  assign at_zero  = (q_reg == '0);
  assign boundary = EN & ~LOAD & (UP ? at_top : at_zero);
  assign step_ext = UP ? (q_ext + ONE) : (q_ext - ONE);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_match
    assign eq_bits[gi] = q_reg[gi] ~^ CMP[gi];
  end

  always_comb begin
    q_next   = q_reg;
    ovf_next = ovf_reg & ~CLR_OVF;
    if (LOAD) begin
      q_next = ({1'b0, LDATA} > TOP) ? TOP[WIDTH-1:0] : LDATA;
    end else if (EN) begin
      if (boundary) begin
        // Set beats a simultaneous clear.
        ovf_next = 1'b1;
        if (!SAT) q_next = UP ? '0 : TOP[WIDTH-1:0];
      end else begin
        q_next = step_ext[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      ovf_reg <= ovf_next;
    end
  end

  assign QOUT  = q_reg;
  assign OVF   = ovf_reg;
  assign TC    = boundary;
  assign MATCH = &eq_bits;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: directed vector table, randomized run against a
// behavioural model, BCD cascade and a MODULUS=16 mid-operation reset.
module tb_mod_updown_counter;

  localparam int M = 10;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // main instance, WIDTH=4 MODULUS=10
  logic       rst = 1'b1, en = 1'b0, up = 1'b0, ld = 1'b0, sat = 1'b0, clr = 1'b0;
  logic [3:0] ldata = '0, cmp = '0;
  logic [3:0] q;
  logic       tc, match, ovf;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .RESET(rst), .EN(en), .UP(up), .LOAD(ld), .LDATA(ldata),
    .SAT(sat), .CMP(cmp), .CLR_OVF(clr), .QOUT(q), .TC(tc), .MATCH(match), .OVF(ovf)
  );

  // BCD cascade pair
  logic       c_rst = 1'b1;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, m_lo, m_hi, o_lo, o_hi;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .CLK(CLK), .RESET(c_rst), .EN(1'b1), .UP(1'b1), .LOAD(1'b0), .LDATA(4'd0),
    .SAT(1'b0), .CMP(4'd0), .CLR_OVF(1'b0), .QOUT(q_lo), .TC(tc_lo), .MATCH(m_lo), .OVF(o_lo)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .CLK(CLK), .RESET(c_rst), .EN(tc_lo), .UP(1'b1), .LOAD(1'b0), .LDATA(4'd0),
    .SAT(1'b0), .CMP(4'd0), .CLR_OVF(1'b0), .QOUT(q_hi), .TC(tc_hi), .MATCH(m_hi), .OVF(o_hi)
  );

  // full-binary instance, MODULUS = 2^WIDTH
  logic       r16 = 1'b1, en16 = 1'b0;
  logic [3:0] q16;
  logic       tc16, m16, ovf16;

  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .CLK(CLK), .RESET(r16), .EN(en16), .UP(1'b1), .LOAD(1'b0), .LDATA(4'd0),
    .SAT(1'b0), .CMP(4'd0), .CLR_OVF(1'b0), .QOUT(q16), .TC(tc16), .MATCH(m16), .OVF(ovf16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, en, up, ld;
    logic [3:0] ldata;
    logic       sat;
    logic [3:0] cmp;
    logic       clr;
    logic       chk_comb;
    logic       tc, match;
    logic [3:0] q;
    logic       ovf;
  } vec_t;

  function automatic vec_t mk(input logic r, e, u, l, input int d, input logic s,
                              input int c, input logic cl, input logic cc,
                              input logic t, mt, input int qq, input logic o);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.ldata = 4'(d); v.sat = s;
    v.cmp = 4'(c); v.clr = cl; v.chk_comb = cc; v.tc = t; v.match = mt;
    v.q = 4'(qq); v.ovf = o;
    return v;
  endfunction

  vec_t vecs[$];

  // Drive at negedge, check combinational outputs just after, registered ones after posedge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge CLK);
    rst = v.rst; en = v.en; up = v.up; ld = v.ld; ldata = v.ldata;
    sat = v.sat; cmp = v.cmp; clr = v.clr;
    #1;
    if (v.chk_comb) begin
      chk($sformatf("vec%0d_tc", idx), 32'(tc), 32'(v.tc));
      chk($sformatf("vec%0d_match", idx), 32'(match), 32'(v.match));
    end
    @(posedge CLK);
    #1;
    chk($sformatf("vec%0d_q", idx), 32'(q), 32'(v.q));
    chk($sformatf("vec%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
    $display("vec %0d: rst=%0b en=%0b up=%0b ld=%0b ldata=%0d sat=%0b cmp=%0d clr=%0b -> q=%0d ovf=%0b",
             idx, v.rst, v.en, v.up, v.ld, v.ldata, v.sat, v.cmp, v.clr, q, ovf);
  endtask

  initial begin
    // reset then count up with wrap
    vecs.push_back(mk(1,0,0,0,0,0,15,0, 0,0,0,0,0));
    for (int i = 0; i < 12; i++)
      vecs.push_back(mk(0,1,1,0,0,0,15,0, 1,(i % 10) == 9,0,(i + 1) % 10,i >= 9));
    // load 2, count down into saturation, clear behaviour
    vecs.push_back(mk(0,0,0,1,2,0,15,1, 1,0,0,2,0));
    vecs.push_back(mk(0,1,0,0,0,1,15,0, 1,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,1,15,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,1,15,0, 1,1,0,0,1));
    vecs.push_back(mk(0,1,0,0,0,1,15,0, 1,1,0,0,1));
    vecs.push_back(mk(0,1,0,0,0,1,15,1, 1,1,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,15,1, 1,0,0,0,0));
    // down wrap, load clamp and priority
    vecs.push_back(mk(0,1,0,0,0,0,15,0, 1,1,0,9,1));
    vecs.push_back(mk(0,1,1,1,13,0,15,0, 1,0,0,9,1));
    vecs.push_back(mk(0,1,0,1,7,0,15,0, 1,0,0,7,1));
    vecs.push_back(mk(0,0,0,1,10,0,15,0, 1,0,0,9,1));
    vecs.push_back(mk(0,0,0,1,9,0,9,0, 1,0,1,9,1));
    vecs.push_back(mk(1,1,1,1,5,0,15,0, 1,0,0,0,0));
    // compare and direction flip
    vecs.push_back(mk(0,0,0,1,3,0,5,0, 1,0,0,3,0));
    vecs.push_back(mk(0,1,1,0,0,0,5,0, 1,0,0,4,0));
    vecs.push_back(mk(0,1,1,0,0,0,5,0, 1,0,0,5,0));
    vecs.push_back(mk(0,1,1,0,0,0,5,0, 1,0,1,6,0));
    vecs.push_back(mk(0,1,0,0,0,0,5,0, 1,0,0,5,0));
    vecs.push_back(mk(0,1,0,0,0,0,5,0, 1,0,1,4,0));
    vecs.push_back(mk(0,0,0,0,0,0,4,0, 1,0,1,4,0));
    vecs.push_back(mk(0,0,1,0,0,0,5,0, 1,0,0,4,0));

    foreach (vecs[i]) apply(vecs[i], i);

    // randomized run against a modular-arithmetic model
    begin
      int q_m = 0;
      bit ovf_m = 0;
      for (int n = 0; n < 400; n++) begin
        int  raw, nq;
        bit  exp_tc, oob;
        @(negedge CLK);
        rst   = (n == 0) || ($urandom_range(0, 49) == 0);
        ld    = ($urandom_range(0, 7) == 0);
        en    = ($urandom_range(0, 3) != 0);
        up    = 1'($urandom_range(0, 1));
        sat   = 1'($urandom_range(0, 1));
        clr   = ($urandom_range(0, 7) == 0);
        ldata = 4'($urandom_range(0, 15));
        cmp   = 4'($urandom_range(0, 15));
        raw    = up ? q_m + 1 : q_m - 1;
        oob    = (raw < 0) || (raw > M - 1);
        exp_tc = en && !ld && oob;
        #1;
        if (n != 0) begin
          chk($sformatf("rnd%0d_tc", n), 32'(tc), 32'(exp_tc));
          chk($sformatf("rnd%0d_match", n), 32'(match), 32'(q_m == int'(cmp)));
        end
        if (rst) begin
          nq = 0; ovf_m = 0;
        end else begin
          ovf_m = exp_tc ? 1'b1 : (ovf_m && !clr);
          if (ld)         nq = (int'(ldata) > M - 1) ? M - 1 : int'(ldata);
          else if (!en)   nq = q_m;
          else if (!oob)  nq = raw;
          else if (sat)   nq = q_m;
          else            nq = (raw + M) % M;
        end
        q_m = nq;
        @(posedge CLK);
        #1;
        chk($sformatf("rnd%0d_q", n), 32'(q), 32'(q_m));
        chk($sformatf("rnd%0d_ovf", n), 32'(ovf), 32'(ovf_m));
        $display("rnd %0d: rst=%0b ld=%0b en=%0b up=%0b sat=%0b clr=%0b -> q=%0d ovf=%0b (model %0d %0b)",
                 n, rst, ld, en, up, sat, clr, q, ovf, q_m, ovf_m);
      end
    end

    // BCD cascade
    @(negedge CLK);
    c_rst = 1'b0;
    repeat (37) @(posedge CLK);
    #1;
    chk("cascade37", 32'({q_hi, q_lo}), 32'(8'h37));
    $display("cascade after 37 clocks: %0d%0d", q_hi, q_lo);
    repeat (62) @(posedge CLK);
    #1;
    chk("cascade99", 32'({q_hi, q_lo}), 32'(8'h99));
    chk("cascade99_tc_hi", 32'(tc_hi), 32'd1);
    $display("cascade after 99 clocks: %0d%0d tc_hi=%0b", q_hi, q_lo, tc_hi);
    @(posedge CLK);
    #1;
    chk("cascade100", 32'({q_hi, q_lo}), 32'(8'h00));
    chk("cascade100_tc_hi", 32'(tc_hi), 32'd0);
    $display("cascade after 100 clocks: %0d%0d tc_hi=%0b", q_hi, q_lo, tc_hi);

    // MODULUS=16 mid-operation reset
    @(negedge CLK);
    r16 = 1'b0; en16 = 1'b1;
    repeat (30) @(posedge CLK);
    #1;
    chk("m16_q14", 32'(q16), 32'd14);
    chk("m16_ovf", 32'(ovf16), 32'd1);
    $display("m16 after 30 clocks: q=%0d ovf=%0b", q16, ovf16);
    @(negedge CLK);
    r16 = 1'b1;
    @(posedge CLK);
    #1;
    chk("m16_rst_q", 32'(q16), 32'd0);
    chk("m16_rst_ovf", 32'(ovf16), 32'd0);
    $display("m16 reset: q=%0d ovf=%0b", q16, ovf16);
    @(negedge CLK);
    r16 = 1'b0;
    @(posedge CLK);
    #1;
    chk("m16_resume", 32'(q16), 32'd1);
    $display("m16 resume: q=%0d", q16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised synchronous up/down counter. It generalises the team's fixed 4-bit up counter to any width and any modulus, and adds parallel load, enable, a wrap or saturate mode, a compare match and a sticky overflow flag. It also provides a cascade carry (TC) for building wider counters from several instances. It is used as the general-purpose counter/timer primitive in the counter directory.

Parameters:
WIDTH, 4, bit width of QOUT, LDATA, CMP; legal range 1..16
MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2^WIDTH; an illegal value is a static elaboration error

Ports:
CLK  input  1  clock; all state updates on the posedge
RESET  input  1  synchronous, active-high reset
EN  input  1  count enable; also acts as carry-in when cascading
UP  input  1  direction: 1 = increment, 0 = decrement
LOAD  input  1  synchronous parallel load
LDATA  input  WIDTH  load value
SAT  input  1  boundary mode: 0 = wrap, 1 = saturate
CMP  input  WIDTH  compare value
CLR_OVF  input  1  clears the sticky OVF flag
QOUT  output  WIDTH  current count (registered)
TC  output  1  terminal count / cascade carry (combinational)
MATCH  output  1  QOUT equals CMP (combinational)
OVF  output  1  sticky boundary-event flag (registered)

Behaviour:
- Reset state: on a posedge with RESET=1, QOUT=0 and OVF=0. RESET overrides every other input, including during a load or a count.
- Register update priority, evaluated at each posedge: RESET > LOAD > EN count > hold.
- LOAD=1:
  - QOUT <= LDATA if LDATA <= MODULUS-1; otherwise QOUT <= MODULUS-1 (clamped).
  - Takes effect one cycle later. EN, UP and SAT are ignored in that cycle.
  - A load never sets OVF.
- EN=1, LOAD=0, UP=1:
  - If QOUT < MODULUS-1, QOUT <= QOUT+1.
  - If QOUT == MODULUS-1: with SAT=0, QOUT <= 0; with SAT=1, QOUT holds. In both cases OVF <= 1.
- EN=1, LOAD=0, UP=0:
  - If QOUT > 0, QOUT <= QOUT-1.
  - If QOUT == 0: with SAT=0, QOUT <= MODULUS-1; with SAT=1, QOUT holds. In both cases OVF <= 1.
- EN=0, LOAD=0: QOUT holds.
- Arithmetic: internal arithmetic is WIDTH+1 bits so no unintended wrap occurs at 2^WIDTH. When MODULUS = 2^WIDTH, wrapping is the natural binary wrap.
- TC:
  - TC = EN & ~LOAD & ((UP & QOUT==MODULUS-1) | (~UP & QOUT==0)).
  - Zero latency; it is high in the cycle before the boundary edge.
  - It is asserted in saturate mode as well.
  - For cascading, connect instance N's TC to instance N+1's EN, with shared UP and SAT=0.
- MATCH = (QOUT == CMP). Purely combinational; it follows CMP changes in the same cycle.
- OVF:
  - Set on any boundary event (wrap, or a saturated hold with EN=1).
  - Cleared by CLR_OVF=1 at the next posedge.
  - If a set and a clear occur in the same cycle, the set wins and OVF stays 1.
  - Cleared by RESET.
- Direction change: UP may toggle on any cycle. The new direction applies at the next posedge with no bubble.
- Out-of-range state is unreachable. QOUT > MODULUS-1 cannot be produced by reset, load or counting.
- No X propagation: each output has a defined value from the first reset onward.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10 unless stated otherwise.
1. Reset and up count: RESET for 1 cycle, then EN=1, UP=1, SAT=0 for 12 cycles -> QOUT = 0,1,…,9,0,1. TC is high only while QOUT=9. OVF=1 from the cycle after 9→0.
2. Down and saturate: LOAD with LDATA=2, then EN=1, UP=0, SAT=1 for 4 cycles -> QOUT = 2,1,0,0,0. TC is high while QOUT=0. OVF sets at the first held 0. CLR_OVF pulse during continued saturation -> OVF stays 1. Set EN=0, then pulse CLR_OVF -> OVF=0.
3. Load clamp and priority: LOAD=1 with LDATA=13 and EN=1, UP=1 -> QOUT=9 and OVF unchanged. LOAD=1 and RESET=1 together -> QOUT=0.
4. Compare and direction flip: CMP=5; count up from 3 -> MATCH=1 exactly while QOUT=5. Toggle UP=0 at QOUT=6 -> the next values are 5,4, and MATCH re-asserts at 5.
5. Cascade with two instances of WIDTH=4, MODULUS=10 (BCD), EN of the low digit tied to 1 -> after 99 clocks {hi,lo} = 9,9. The next clock gives 0,0, with the high digit's TC high in the preceding cycle.
6. Mid-operation reset, with MODULUS=16: count up to QOUT=14 with OVF=1, then assert RESET for one cycle while EN=1 -> QOUT=0, OVF=0. Counting resumes at 1 on the following cycle.
